// File: rtl/text_writer_pkg.sv
// Shared constants and types for the text writer.
// Control codes, printable range, display colours/font, FSM states.
package text_writer_pkg;

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  localparam logic [11:0] FG_COLOUR = 12'hFFF;
  localparam logic [11:0] BG_COLOUR = 12'h000;
  localparam int FONT_W = 8;
  localparam int FONT_H = 8;

  typedef enum logic {
    IDLE,
    CLEAR
  } wrState_t;

  function automatic logic isPrint(
    input logic [7:0] c
  );
    return (c >= PRINT_LO) && (c <= PRINT_HI);
  endfunction

endpackage

// File: rtl/text_writer_cursor.sv
// Text cursor: column/row counter with wrap.
// Ports: clk, rst_n, one-hot controls in; col, row out.
module text_cursor
  import text_writer_pkg::*;
#(
  parameter int COLS = 16,
  parameter int ROWS = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    advance,
  input  logic                    back,
  input  logic                    newline,
  input  logic                    cr,
  input  logic                    home,
  output logic [$clog2(COLS)-1:0] col,
  output logic [$clog2(ROWS)-1:0] row
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);

  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

  // Row arithmetic wraps naturally: ROWS is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else begin
      unique case (1'b1)
        home: begin
          col <= '0;
          row <= '0;
        end
        advance: begin
          if (col == LAST_COL) begin
            col <= '0;
            row <= row + RW'(1);
          end else begin
            col <= col + CW'(1);
          end
        end
        back: begin
          if (col != '0) begin
            col <= col - CW'(1);
          end else if (row != '0) begin
            col <= LAST_COL;
            row <= row - RW'(1);
          end
        end
        newline: begin
          col <= '0;
          row <= row + RW'(1);
        end
        cr: col <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/text_writer.sv
// Character stream to text-RAM writer with cursor and clear.
// Ports: din/din_valid/din_ready in, ram_* write port, cursor, busy.
module text_writer
  import text_writer_pkg::*;
#(
  parameter int         COLS   = 16,
  parameter int         ROWS   = 16,
  parameter int         ADDR_W = 8,
  parameter logic [7:0] BLANK  = 8'h20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              din,
  input  logic                    din_valid,
  output logic                    din_ready,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [7:0]              ram_din,
  output logic                    ram_we,
  output logic [$clog2(COLS)-1:0] cur_col,
  output logic [$clog2(ROWS)-1:0] cur_row,
  output logic                    busy
);

  localparam logic [ADDR_W:0] CLR_END = (ADDR_W + 1)'(COLS * ROWS);

  wrState_t          state;
  wrState_t          nextState;
  logic              rdyQ;
  logic [ADDR_W:0]   clrCnt;
  logic [ADDR_W:0]   cntD;
  logic              weD;
  logic [ADDR_W-1:0] addrD;
  logic [7:0]        dinD;
  logic [ADDR_W-1:0] curAddr;
  logic [ADDR_W-1:0] prevAddr;
  logic              accept;
  logic              adv;
  logic              back;
  logic              nl;
  logic              cr;
  logic              home;

  // Row-major: row*COLS + col is a plain concatenation.
  assign curAddr  = {cur_row, cur_col};
  // Backspace target; pinned at 0 for the home position.
  assign prevAddr = (curAddr == '0) ? '0 : curAddr - ADDR_W'(1);

  // rdyQ keeps din_ready low until the first edge after reset.
  assign din_ready = rdyQ && (state == IDLE);
  assign busy      = (state == CLEAR);
  assign accept    = din_valid && din_ready;

  always_comb begin
    nextState = state;
    cntD      = clrCnt;
    weD       = 1'b0;
    addrD     = ram_addr;
    dinD      = ram_din;
    adv       = 1'b0;
    back      = 1'b0;
    nl        = 1'b0;
    cr        = 1'b0;
    home      = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          unique case (1'b1)
            isPrint(din): begin
              weD   = 1'b1;
              addrD = curAddr;
              dinD  = din;
              adv   = 1'b1;
            end
            (din == CH_CR): cr = 1'b1;
            (din == CH_LF): nl = 1'b1;
            (din == CH_BS): begin
              weD   = 1'b1;
              addrD = prevAddr;
              dinD  = BLANK;
              back  = 1'b1;
            end
            (din == CH_FF): begin
              nextState = CLEAR;
              weD       = 1'b1;
              addrD     = '0;
              dinD      = BLANK;
              cntD      = (ADDR_W + 1)'(1);
              home      = 1'b1;
            end
            default: ;
          endcase
        end
      end
      CLEAR: begin
        if (clrCnt == CLR_END) begin
          nextState = IDLE;
        end else begin
          weD   = 1'b1;
          addrD = clrCnt[ADDR_W-1:0];
          dinD  = BLANK;
          cntD  = clrCnt + (ADDR_W + 1)'(1);
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rdyQ     <= 1'b0;
      clrCnt   <= '0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
    end else begin
      state    <= nextState;
      rdyQ     <= 1'b1;
      clrCnt   <= cntD;
      ram_we   <= weD;
      ram_addr <= addrD;
      ram_din  <= dinD;
    end
  end

  text_cursor #(
    .COLS(COLS),
    .ROWS(ROWS)
  ) uCursor (
    .clk    (clk),
    .rst_n  (rst_n),
    .advance(adv),
    .back   (back),
    .newline(nl),
    .cr     (cr),
    .home   (home),
    .col    (cur_col),
    .row    (cur_row)
  );

endmodule

// File: tb/tb_text_writer.sv
// Testbench for text_writer.
// Scoreboard of expected RAM writes plus directed cursor checks.
module tb_text_writer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;
  logic       din_ready;
  logic [7:0] ram_addr;
  logic [7:0] ram_din;
  logic       ram_we;
  logic [3:0] cur_col;
  logic [3:0] cur_row;
  logic       busy;

  int tests = 0;
  int fails = 0;
  logic [15:0] sb[$];

  always #5 clk = ~clk;

  text_writer #(
    .COLS(16),
    .ROWS(16),
    .ADDR_W(8),
    .BLANK(8'h20)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .din_valid(din_valid),
    .din_ready(din_ready),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_we   (ram_we),
    .cur_col  (cur_col),
    .cur_row  (cur_row),
    .busy     (busy)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [7:0] b);
    @(negedge clk);
    din       = b;
    din_valid = 1'b1;
  endtask

  task automatic idle();
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic checkCursor(
    input string      tag,
    input logic [3:0] c,
    input logic [3:0] r
  );
    check({tag, "_col"}, 32'(cur_col), 32'(c));
    check({tag, "_row"}, 32'(cur_row), 32'(r));
  endtask

  // Every write the DUT makes must match the oldest expected one.
  always @(negedge clk) begin
    logic [15:0] e;
    if (rst_n && ram_we === 1'b1) begin
      check("wrPending", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("wrAddrData", 32'({ram_addr, ram_din}), 32'(e));
      end
    end
  end

  initial begin
    int good;
    int found;

    #12;
    check("rstWe", 32'(ram_we), 32'd0);
    check("rstAddr", 32'(ram_addr), 32'd0);
    check("rstDin", 32'(ram_din), 32'd0);
    check("rstBusy", 32'(busy), 32'd0);
    check("rstRdy", 32'(din_ready), 32'd0);
    checkCursor("rst", 4'd0, 4'd0);
    #1 rst_n = 1'b1;
    #1 check("rdyBeforeEdge", 32'(din_ready), 32'd0);
    @(negedge clk);
    check("rdyAfterEdge", 32'(din_ready), 32'd1);

    sb.push_back({8'd0, 8'h41});
    put(8'h41);
    sb.push_back({8'd1, 8'h42});
    put(8'h42);
    idle();
    idle();
    checkCursor("AB", 4'd2, 4'd0);
    check("sbEmptyAB", 32'(sb.size()), 32'd0);

    for (int i = 2; i < 255; i++) begin
      sb.push_back({8'(i), 8'h21 + 8'(i % 90)});
      put(8'h21 + 8'(i % 90));
    end
    idle();
    idle();
    checkCursor("fill", 4'd15, 4'd15);

    sb.push_back({8'd255, 8'h5A});
    put(8'h5A);
    idle();
    idle();
    checkCursor("wrapZ", 4'd0, 4'd0);
    put(8'h0A);
    idle();
    idle();
    checkCursor("lf", 4'd0, 4'd1);
    check("sbEmptyLf", 32'(sb.size()), 32'd0);

    sb.push_back({8'd15, 8'h20});
    put(8'h08);
    idle();
    idle();
    checkCursor("bs1", 4'd15, 4'd0);
    put(8'h0D);
    idle();
    idle();
    checkCursor("cr", 4'd0, 4'd0);
    sb.push_back({8'd0, 8'h20});
    put(8'h08);
    idle();
    idle();
    checkCursor("bsHome", 4'd0, 4'd0);
    check("sbEmptyBs", 32'(sb.size()), 32'd0);

    for (int i = 0; i < 256; i++) sb.push_back({8'(i), 8'h20});
    put(8'h0C);
    idle();
    good = 0;
    for (int k = 0; k < 256; k++) begin
      if (busy === 1'b1 && din_ready === 1'b0) good++;
      @(negedge clk);
    end
    check("clrBusyCycles", 32'(good), 32'd256);
    check("clrDoneBusy", 32'(busy), 32'd0);
    check("clrDoneRdy", 32'(din_ready), 32'd1);
    checkCursor("clrDone", 4'd0, 4'd0);
    check("sbEmptyClr", 32'(sb.size()), 32'd0);

    for (int i = 0; i < 256; i++) sb.push_back({8'(i), 8'h20});
    put(8'h0C);
    idle();
    found = 0;
    for (int k = 0; k < 300 && found == 0; k++) begin
      if (ram_we === 1'b1 && ram_addr === 8'd100) found = 1;
      else @(negedge clk);
    end
    check("clrAddr100", 32'(found), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("midRstWe", 32'(ram_we), 32'd0);
    check("midRstAddr", 32'(ram_addr), 32'd0);
    check("midRstDin", 32'(ram_din), 32'd0);
    check("midRstBusy", 32'(busy), 32'd0);
    check("midRstRdy", 32'(din_ready), 32'd0);
    checkCursor("midRst", 4'd0, 4'd0);
    sb.delete();
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("noResumeBusy", 32'(busy), 32'd0);
    check("noResumeRdy", 32'(din_ready), 32'd1);
    sb.push_back({8'd0, 8'h51});
    put(8'h51);
    idle();
    idle();
    checkCursor("q", 4'd1, 4'd0);
    check("sbEmptyQ", 32'(sb.size()), 32'd0);

    put(8'h07);
    check("rdyBel", 32'(din_ready), 32'd1);
    put(8'h90);
    check("rdyHigh", 32'(din_ready), 32'd1);
    idle();
    idle();
    checkCursor("discard", 4'd1, 4'd0);
    check("sbEmptyEnd", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
